// File: rtl/mux_sel_arbiter_pkg.sv
// mux_sel_arbiter_pkg: shared widths and state encoding for the select arbiter and its helpers
package mux_sel_arbiter_pkg;
  localparam int SEL_W  = 2;
  localparam int NUM_IN = 4;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;
endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// mux_sel_arbiter_rr_pick: combinational rotating-priority pick (rotate, priority-encode, un-rotate)
module mux_sel_arbiter_rr_pick
  import mux_sel_arbiter_pkg::*;
(
  input  logic [NUM_IN-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic [SEL_W-1:0]  pick_o,
  output logic              any_o
);
  logic [2*NUM_IN-1:0] dbl;
  logic [NUM_IN-1:0]   rot;
  logic [SEL_W-1:0]    off;
  always_comb begin
    dbl = {req_i, req_i} >> ptr_i;
    rot = dbl[NUM_IN-1:0];
    off = '0;
    for (int k = NUM_IN - 1; k >= 0; k--)
      if (rot[k]) off = SEL_W'(k);
    pick_o = ptr_i + off;
    any_o  = |req_i;
  end
endmodule

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin arbiter driving a registered sel bus with valid/ready and burst hold
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 1,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              sel_valid,
  output logic              sel_last
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d, pick_ptr, pick;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d, any, hold;
  // In GRANT the pick is only used on rotation, where the pointer moves past the current winner.
  assign pick_ptr = (state_q == ST_GRANT) ? sel_q + 1'b1 : ptr_q;
  mux_sel_arbiter_rr_pick u_pick (
    .req_i  (req),
    .ptr_i  (pick_ptr),
    .pick_o (pick),
    .any_o  (any)
  );
  assign hold = req[sel_q] && (cnt_q < LAST_CNT);
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (state_q == ST_IDLE) begin
      if (any) begin
        state_d = ST_GRANT;
        sel_d   = pick;
        cnt_d   = '0;
        last_d  = (LAST_CNT == '0);
      end
    end else if (out_ready) begin
      if (hold) begin
        cnt_d  = cnt_q + 1'b1;
        last_d = (cnt_q + 1'b1) == LAST_CNT;
      end else begin
        ptr_d   = sel_q + 1'b1;
        cnt_d   = '0;
        state_d = any ? ST_GRANT : ST_IDLE;
        sel_d   = any ? pick : sel_q;
        last_d  = any && (LAST_CNT == '0);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end
  assign sel       = sel_q;
  assign sel_valid = (state_q == ST_GRANT);
  assign sel_last  = last_q;
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: scoreboard bench running a pure round-robin and a burst-of-3 arbiter side by side
module tb_mux_sel_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0;
  logic       out_ready = 1'b0;
  logic [1:0] sel1, sel3;
  logic       v1, v3, l1, l3;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.MAX_BURST(1), .CNT_W(4)) u_mb1 (
    .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
    .sel(sel1), .sel_valid(v1), .sel_last(l1)
  );
  mux_sel_arbiter #(.MAX_BURST(3), .CNT_W(4)) u_mb3 (
    .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
    .sel(sel3), .sel_valid(v3), .sel_last(l3)
  );

  typedef struct {
    bit valid;
    int sel;
    int ptr;
    int n;
  } mdl_t;
  typedef logic [3:0] obs_t;

  mdl_t m1, m3;
  obs_t q1[$], q3[$];

  function automatic int pick(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  // Reference: n counts transfers already made in the current grant.
  function automatic mdl_t step(mdl_t m, logic [3:0] r, bit rd, int mb);
    if (!m.valid) begin
      if (r != 0) begin
        m.valid = 1;
        m.sel = pick(r, m.ptr);
        m.n = 0;
      end
    end else if (rd) begin
      if (r[m.sel] && m.n + 1 < mb) m.n++;
      else begin
        m.ptr = (m.sel + 1) % 4;
        m.n = 0;
        if (r != 0) m.sel = pick(r, m.ptr);
        else m.valid = 0;
      end
    end
    return m;
  endfunction

  function automatic obs_t obs(mdl_t m, int mb);
    return {m.valid, m.valid && (m.n == mb - 1), 2'(m.sel)};
  endfunction

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got valid/last/sel=%b required %b", name, $time, act, exp);
    end
  endtask

  task automatic mreset();
    m1 = '{0, 0, 0, 0};
    m3 = '{0, 0, 0, 0};
  endtask

  task automatic cyc(input logic [3:0] r, input bit rd);
    req = r;
    out_ready = rd;
    @(posedge clk);
    m1 = step(m1, r, rd, 1);
    m3 = step(m3, r, rd, 3);
    q1.push_back(obs(m1, 1));
    q3.push_back(obs(m3, 3));
    #1;
  endtask

  always @(negedge clk) begin
    if (q1.size() > 0) chk("mb1", {v1, l1, sel1}, q1.pop_front());
    if (q3.size() > 0) chk("mb3", {v3, l3, sel3}, q3.pop_front());
  end

  initial begin
    mreset();
    #1;
    chk("reset_mb1", {v1, l1, sel1}, 4'b0);
    chk("reset_mb3", {v3, l3, sel3}, 4'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) cyc(4'b0100, 1);
    repeat (2) cyc(4'b0000, 1);
    repeat (8) cyc(4'b1111, 1);
    repeat (2) cyc(4'b0000, 1);
    repeat (5) cyc(4'b0011, 0);
    repeat (3) cyc(4'b0011, 1);
    repeat (2) cyc(4'b0000, 1);
    repeat (8) cyc(4'b0101, 1);
    repeat (2) cyc(4'b0000, 1);
    repeat (2) cyc(4'b1000, 0);
    repeat (2) cyc(4'b0000, 0);
    cyc(4'b0000, 1);
    repeat (2) cyc(4'b0000, 0);
    repeat (3) cyc(4'b1111, 1);
    #2 rst = 1'b1;
    q1.delete();
    q3.delete();
    mreset();
    #1;
    chk("midrst_mb1", {v1, l1, sel1}, 4'b0);
    chk("midrst_mb3", {v3, l3, sel3}, 4'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) cyc(4'b1111, 1);
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom), $urandom_range(0, 3) != 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
